rr_mux_arbiter: RTL and testbench

- Round-robin N-input arbiter plus registered data mux with valid/ready on every port.
- Sits directly upstream of the combinational ternary mux stages. It generates a fair, registered select and the selected data word, so downstream logic receives one stable, timed-out source per transfer instead of a raw select line.
- Single output register stage, so the stage has 1-cycle latency and full throughput of 1 transfer per cycle.

---
 rtl/rr_pkg.sv | 36 +++
 rtl/rr_mux_arbiter_grant.sv | 30 +++
 rtl/rr_mux_arbiter.sv | 78 +++++++
 tb/tb_rr_mux_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared round-robin helpers: circular priority pick and default sizes.
package rr_pkg;

    localparam int RR_MAX_N   = 16;
    localparam int RR_IDX_W   = 4;
    localparam int N_IN_DEF   = 4;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req among the lowest n positions, scanning circularly from ptr.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        rr_pick_t res;
        int       pos;
        res = '0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((k < n) && !res.found && req[pos[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_grant.sv
// Combinational circular priority picker: first requester at or after ptr.
module rr_grant
    import rr_pkg::*;
#(
    parameter  int N_IN  = N_IN_DEF,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_found
);

    logic [RR_MAX_N-1:0] w_req;
    logic [RR_IDX_W-1:0] w_ptr;
    rr_pick_t            w_pick;

    always_comb begin
        w_req             = '0;
        w_req[N_IN-1:0]   = i_req;
        w_ptr             = '0;
        w_ptr[SEL_W-1:0]  = i_ptr;
        w_pick            = rr_pick(w_req, w_ptr, N_IN);
    end

    // The range guard never trips for a legal ptr; it keeps a stray index from granting.
    assign o_grant = w_pick.idx[SEL_W-1:0];
    assign o_found = w_pick.found && (int'(w_pick.idx) < N_IN);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a single registered output stage (valid/ready on every port).
module rr_mux_arbiter
    import rr_pkg::*;
#(
    parameter  int N_IN   = N_IN_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN-1:0]        in_valid,
    input  logic [N_IN*DATA_W-1:0] in_data,
    output logic [N_IN-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_src,
    input  logic                   out_ready
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_src;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_load;
    logic [N_IN-1:0]   w_req;
    logic [SEL_W-1:0]  w_grant;
    logic              w_found;
    logic [SEL_W-1:0]  w_ptr_next;
    logic [DATA_W-1:0] w_data_arr [N_IN];
    logic [DATA_W-1:0] w_sel_data;

    // Output register empty or draining this cycle; nothing is accepted during reset.
    assign w_load = !rst && (!r_out_valid || out_ready);
    assign w_req  = in_valid & {N_IN{w_load}};

    rr_grant #(
        .N_IN    (N_IN)
    ) u_grant (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_port
            assign w_data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
            assign in_ready[gi]   = w_found && (w_grant == SEL_W'(gi));
        end
    endgenerate

    assign w_sel_data = w_data_arr[w_grant];
    assign w_ptr_next = (w_grant == SEL_W'(N_IN - 1)) ? '0 : w_grant + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_src   <= w_grant;
                r_ptr       <= w_ptr_next;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: behavioural arbiter model, scoreboard, directed and random traffic.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    bit       m_valid;
    bit [7:0] m_data;
    int       m_src;
    int       m_ptr;
    int       last_g;
    int       waits [N];

    typedef struct {
        logic [7:0] d;
        int         s;
    } word_t;
    word_t sb [$];

    rr_mux_arbiter #(
        .N_IN      (N),
        .DATA_W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model at negedge, then advance the model.
    task automatic step();
        int         g;
        bit         ld;
        logic [N-1:0] exp_rdy;
        word_t      w;
        @(negedge clk);
        ld = !rst && (!m_valid || out_ready);
        g  = -1;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && in_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        check("in_ready",  32'(in_ready),  32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_src",   32'(out_src),   32'(m_src));
        if (rst) begin
            sb.delete();
            for (int i = 0; i < N; i++) waits[i] = 0;
        end else begin
            if (m_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    w = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(w.d));
                    check("sb_src",  32'(out_src),  32'(w.s));
                end
            end
            if (g >= 0) begin
                w.d = in_data[g*W +: W];
                w.s = g;
                sb.push_back(w);
                for (int i = 0; i < N; i++) begin
                    if (i == g) begin
                        check("wait_bound", 32'(waits[i] > N - 1), 32'd0);
                        waits[i] = 0;
                    end else if (in_valid[i]) begin
                        waits[i]++;
                    end
                end
            end
        end
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_src   = g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        last_g = rst ? -1 : g;
        @(posedge clk);
        #1;
    endtask

    int       seq [5] = '{0, 1, 2, 3, 0};
    bit [N-1:0] pend;

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; last_g = -1;
        for (int i = 0; i < N; i++) waits[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_src",   32'(out_src),   32'd0);

        // All requesting: strict rotation
        rst = 1'b0; in_valid = 4'b1111; in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rot_src",  32'(out_src),  32'(seq[k]));
            check("rot_data", 32'(out_data), 32'(8'hA0 + seq[k]));
        end

        // Lone request on the last input, then pointer wrap
        rst = 1'b1; step(); rst = 1'b0;
        in_valid = 4'b1000; #1;
        check("lone_ready", 32'(in_ready), 32'h8);
        step();
        check("lone_data", 32'(out_data), 32'hA3);
        check("lone_src",  32'(out_src),  32'd3);
        in_valid = 4'b0000; #1;
        check("lone_ready_off", 32'(in_ready), 32'h0);
        step();
        in_valid = 4'b1111; step();
        check("wrap_src", 32'(out_src), 32'd0);

        // Stall for three cycles, then release
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_src",  32'(out_src),  32'd0);
            check("stall_data", 32'(out_data), 32'hA0);
            check("stall_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1; #1;
        check("release_ready", 32'(in_ready), 32'h2);
        step();
        check("release_src", 32'(out_src), 32'd1);

        // Sparse requests 0101 starting from ptr=1
        rst = 1'b1; step(); rst = 1'b0;
        in_valid = 4'b0001; step();
        in_valid = 4'b0101; step();
        check("sparse_src0", 32'(out_src), 32'd2);
        step();
        check("sparse_src1", 32'(out_src), 32'd0);
        in_valid = 4'b0000; step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Reset during a stall
        in_valid = 4'b1111; step();
        out_ready = 1'b0; step();
        rst = 1'b1; step();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data",  32'(out_data),  32'd0);
        check("midrst_src",   32'(out_src),   32'd0);
        rst = 1'b0; out_ready = 1'b1; step();
        check("postrst_src", 32'(out_src), 32'd0);

        // Random traffic respecting the hold-until-ready protocol
        in_valid = '0; step();
        pend = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    in_data[i*W +: W] = 8'($urandom);
                end
            end
            in_valid = pend;
            step();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
